adder_sum_pipe: RTL

ADDER_SUM_PIPE -- requirements
Module: adder_sum_pipe

---
 rtl/adder_sum_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/adder_sum_pipe.sv
// adder_sum_pipe: final two stages of a 64-bit hybrid prefix adder.
// S1 registers the bit-level propagate/generate terms and the eight
// group-resolved carries; S2 fills in the intra-group carries and
// registers sum, carry-out and the optional zero/overflow flags.
// Valid/ready handshake on both sides, full throughput when unstalled.
module adder_sum_pipe #(
    parameter int unsigned FLAG_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:0] bit_p,
    input  logic [64:0] bit_g,
    input  logic [63:0] grp_g,
    input  logic [63:0] grp_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum,
    output logic        cout,
    output logic        zero,
    output logic        ovf
);

    logic        s1_v_q, s1_v_d;
    logic        s2_v_q, s2_v_d;
    logic        s1_load, s2_load;

    logic [64:0] p_q, g_q;
    logic [7:0]  rc_q, rc_d;

    logic [63:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;

    logic [63:0] c;
    logic [7:0]  grp_cin;
    logic        carry;

    // Only the group-boundary carries of the prefix tree are consumed.
    logic        unused_prefix;
    assign unused_prefix = ^{grp_p, grp_g};

    // Pick G[8k+7:0] out of the prefix-tree result.
    always_comb begin
        rc_d = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            rc_d[k] = grp_g[8*k+7];
        end
    end

    // Handshake: S1 loads on input transfer, S2 drains S1 when it has room.
    always_comb begin
        in_ready = rst_n && (!s1_v_q || !s2_v_q || out_ready);
        s1_load  = in_valid && in_ready;
        s2_load  = s1_v_q && (!s2_v_q || out_ready);
        s1_v_d   = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_v_q);
        s2_v_d   = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_v_q);
    end

    // Intra-group ripple seeded by the resolved carry of the group below;
    // group 0 is seeded by 0 so that c[0] = bit_g[0] (p[0] is always 0).
    always_comb begin
        c       = '0;
        carry   = 1'b0;
        grp_cin = {rc_q[6:0], 1'b0};
        for (int unsigned k = 0; k < 8; k++) begin
            carry = grp_cin[k];
            for (int unsigned j = 0; j < 8; j++) begin
                carry        = g_q[8*k+j] | (p_q[8*k+j] & carry);
                c[8*k+j]     = carry;
            end
        end
        cout_d = g_q[64] | (p_q[64] & c[63]);
        sum_d  = p_q[64:1] ^ c;
        if (FLAG_EN != 0) begin
            zero_d = ~|sum_d;
            ovf_d  = c[63] ^ cout_d;
        end else begin
            zero_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    // Stage valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
        end
    end

    // S1 payload: bit-level terms and resolved group carries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q  <= '0;
            g_q  <= '0;
            rc_q <= '0;
        end else if (s1_load) begin
            p_q  <= bit_p;
            g_q  <= bit_g;
            rc_q <= rc_d;
        end
    end

    // S2 payload: final result, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (s2_load) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = s2_v_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule
